// File: rtl/countdown_controller.sv
// -----------------------------------------------------------------------------
// countdown_controller
//
// Sequencing controller for the bomb countdown. Runs the arm/pause/defuse/
// explode state machine, keeps the remaining minutes:seconds, and drives the
// enable/clear controls of the external one-second timer.
//
// Ports
//   clk                  in   system clock, rising edge
//   async_nreset         in   active-low reset, sampled synchronously on clk
//   load                 in   latch preset_min/preset_sec (clamped, 00:00 ignored)
//   preset_min[6:0]      in   preset minutes, binary (clamped to 99)
//   preset_sec[5:0]      in   preset seconds, binary (clamped to 59)
//   arm                  in   start / resume the countdown
//   pause                in   freeze the countdown
//   defuse               in   stop the countdown as defused
//   second_elapsed       in   one-cycle strobe per second from the timer
//   half_second_elapsed  in   one-cycle strobe per half second from the timer
//   timer_enable         out  timer enable (ARMED only)
//   timer_clear          out  timer clear (IDLE, READY, DEFUSED, EXPLODED)
//   minutes[6:0]         out  remaining minutes, 0..99
//   seconds[5:0]         out  remaining seconds, 0..59
//   state[2:0]           out  current state code
//   blink                out  display blink control (registered)
//   defused              out  high in DEFUSED
//   exploded             out  high in EXPLODED
// -----------------------------------------------------------------------------
module countdown_controller (
    input  logic       clk,
    input  logic       async_nreset,
    input  logic       load,
    input  logic [6:0] preset_min,
    input  logic [5:0] preset_sec,
    input  logic       arm,
    input  logic       pause,
    input  logic       defuse,
    input  logic       second_elapsed,
    input  logic       half_second_elapsed,
    output logic       timer_enable,
    output logic       timer_clear,
    output logic [6:0] minutes,
    output logic [5:0] seconds,
    output logic [2:0] state,
    output logic       blink,
    output logic       defused,
    output logic       exploded
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READY    = 3'd1,
        ST_ARMED    = 3'd2,
        ST_PAUSED   = 3'd3,
        ST_DEFUSED  = 3'd4,
        ST_EXPLODED = 3'd5
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [6:0] min_r;
    logic [6:0] min_nxt_s;
    logic [5:0] sec_r;
    logic [5:0] sec_nxt_s;
    logic       blink_r;
    logic       blink_nxt_s;

    logic [6:0] clamp_min_s;
    logic [5:0] clamp_sec_s;
    logic       load_ok_s;
    logic       one_left_s;
    logic       low_time_s;

    function automatic logic [6:0] clamp_minutes(input logic [6:0] value);
        return (value > 7'd99) ? 7'd99 : value;
    endfunction

    function automatic logic [5:0] clamp_seconds(input logic [5:0] value);
        return (value > 6'd59) ? 6'd59 : value;
    endfunction

    assign clamp_min_s = clamp_minutes(preset_min);
    assign clamp_sec_s = clamp_seconds(preset_sec);
    // A load whose clamped preset is 00:00 is treated as if load were low.
    assign load_ok_s   = load && ((clamp_min_s != 7'd0) || (clamp_sec_s != 6'd0));
    assign one_left_s  = (min_r == 7'd0) && (sec_r == 6'd1);
    assign low_time_s  = (min_r == 7'd0) && (sec_r <= 6'd10);

    // Next-state, next-count and next-blink decode.
    always_comb begin
        state_nxt_s = state_r;
        min_nxt_s   = min_r;
        sec_nxt_s   = sec_r;
        blink_nxt_s = 1'b0;

        case (state_r)
            ST_IDLE, ST_DEFUSED, ST_EXPLODED: begin
                if (load_ok_s) begin
                    state_nxt_s = ST_READY;
                    min_nxt_s   = clamp_min_s;
                    sec_nxt_s   = clamp_sec_s;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_READY: begin
                if (load_ok_s) begin
                    min_nxt_s = clamp_min_s;
                    sec_nxt_s = clamp_sec_s;
                end else if (arm) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_READY;
                end
            end
            ST_ARMED: begin
                if (defuse) begin
                    state_nxt_s = ST_DEFUSED;
                end else if (pause) begin
                    state_nxt_s = ST_PAUSED;
                end else if (second_elapsed) begin
                    if (one_left_s) begin
                        sec_nxt_s   = 6'd0;
                        state_nxt_s = ST_EXPLODED;
                    end else if (sec_r != 6'd0) begin
                        sec_nxt_s = sec_r - 6'd1;
                    end else if (min_r != 7'd0) begin
                        // Borrow a minute when the seconds field is empty.
                        sec_nxt_s = 6'd59;
                        min_nxt_s = min_r - 7'd1;
                    end else begin
                        sec_nxt_s = sec_r;
                    end
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_PAUSED: begin
                if (defuse) begin
                    state_nxt_s = ST_DEFUSED;
                end else if (arm) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_PAUSED;
                end
            end
            default: begin
                // Unused codes recover to IDLE.
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Blink is decided from where the machine is heading so it is
        // already high on the edge that enters EXPLODED.
        if (state_nxt_s == ST_EXPLODED) begin
            blink_nxt_s = 1'b1;
        end else if ((state_r == ST_ARMED) && (state_nxt_s == ST_ARMED) && low_time_s) begin
            blink_nxt_s = blink_r ^ half_second_elapsed;
        end else begin
            blink_nxt_s = 1'b0;
        end
    end

    // State, count and blink registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!async_nreset) begin
            state_r <= ST_IDLE;
            min_r   <= 7'd0;
            sec_r   <= 6'd0;
            blink_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            min_r   <= min_nxt_s;
            sec_r   <= sec_nxt_s;
            blink_r <= blink_nxt_s;
        end
    end

    assign minutes      = min_r;
    assign seconds      = sec_r;
    assign state        = state_r;
    assign blink        = blink_r;
    assign timer_enable = (state_r == ST_ARMED);
    assign timer_clear  = (state_r == ST_IDLE) || (state_r == ST_READY) ||
                          (state_r == ST_DEFUSED) || (state_r == ST_EXPLODED);
    assign defused      = (state_r == ST_DEFUSED);
    assign exploded     = (state_r == ST_EXPLODED);

endmodule

// File: tb/tb_countdown_controller.sv
// -----------------------------------------------------------------------------
// tb_countdown_controller
//
// Self-checking bench for countdown_controller: a table of directed vectors,
// a worked-example sequence driven by a 10-cycle timer model, and a random
// phase checked against a total-seconds reference model.
// -----------------------------------------------------------------------------
module tb_countdown_controller;

    logic       clk = 1'b0;
    logic       async_nreset;
    logic       load;
    logic [6:0] preset_min;
    logic [5:0] preset_sec;
    logic       arm;
    logic       pause;
    logic       defuse;
    logic       second_elapsed;
    logic       half_second_elapsed;
    logic       timer_enable;
    logic       timer_clear;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic [2:0] state;
    logic       blink;
    logic       defused;
    logic       exploded;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    countdown_controller dut (
        .clk                 (clk),
        .async_nreset        (async_nreset),
        .load                (load),
        .preset_min          (preset_min),
        .preset_sec          (preset_sec),
        .arm                 (arm),
        .pause               (pause),
        .defuse              (defuse),
        .second_elapsed      (second_elapsed),
        .half_second_elapsed (half_second_elapsed),
        .timer_enable        (timer_enable),
        .timer_clear         (timer_clear),
        .minutes             (minutes),
        .seconds             (seconds),
        .state               (state),
        .blink               (blink),
        .defused             (defused),
        .exploded            (exploded)
    );

    typedef struct {
        logic       rstn;
        logic       ld;
        logic [6:0] pm;
        logic [5:0] ps;
        logic       ar;
        logic       pa;
        logic       de;
        logic       se;
        logic       hs;
        int         st;
        int         mi;
        int         sc;
        logic       bl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rstn, input logic ld, input int pm, input int ps,
                                input logic ar, input logic pa, input logic de,
                                input logic se, input logic hs,
                                input int st, input int mi, input int sc, input logic bl);
        vec_t v;
        v.rstn = rstn; v.ld = ld; v.pm = pm[6:0]; v.ps = ps[5:0];
        v.ar = ar; v.pa = pa; v.de = de; v.se = se; v.hs = hs;
        v.st = st; v.mi = mi; v.sc = sc; v.bl = bl;
        return v;
    endfunction

    task automatic drive(input logic rstn, input logic ld, input logic [6:0] pm,
                         input logic [5:0] ps, input logic ar, input logic pa,
                         input logic de, input logic se, input logic hs);
        async_nreset        = rstn;
        load                = ld;
        preset_min          = pm;
        preset_sec          = ps;
        arm                 = ar;
        pause               = pa;
        defuse              = de;
        second_elapsed      = se;
        half_second_elapsed = hs;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the expected state/count/blink; the timer
    // and status outputs follow from the expected state code.
    task automatic check(input string name, input int est, input int emin,
                         input int esec, input logic ebl);
        logic een, eclr, edef, eexp;
        een  = (est == 2);
        eclr = (est == 0) || (est == 1) || (est == 4) || (est == 5);
        edef = (est == 4);
        eexp = (est == 5);
        n_vec++;
        if ((int'(state) != est) || (int'(minutes) != emin) || (int'(seconds) != esec) ||
            (blink !== ebl) || (timer_enable !== een) || (timer_clear !== eclr) ||
            (defused !== edef) || (exploded !== eexp)) begin
            n_err++;
            $display("FAIL %s: got st=%0d %0d:%0d en=%b clr=%b bl=%b def=%b ex=%b, expected st=%0d %0d:%0d en=%b clr=%b bl=%b def=%b ex=%b",
                     name, state, minutes, seconds, timer_enable, timer_clear, blink,
                     defused, exploded, est, emin, esec, een, eclr, ebl, edef, eexp);
        end
    endtask

    // Reference model state: state code, remaining time in total seconds, blink.
    int   m_st;
    int   m_cnt;
    logic m_bl;

    task automatic model_step(input logic rstn, input logic ld, input int pm, input int ps,
                              input logic ar, input logic pa, input logic de,
                              input logic se, input logic hs);
        int   pv;
        int   ns;
        int   nc;
        logic ldok;
        if (!rstn) begin
            m_st = 0; m_cnt = 0; m_bl = 1'b0;
        end else begin
            pv   = ((pm > 99) ? 99 : pm) * 60 + ((ps > 59) ? 59 : ps);
            ldok = ld && (pv != 0);
            ns   = m_st;
            nc   = m_cnt;
            case (m_st)
                0, 4, 5: if (ldok) begin ns = 1; nc = pv; end
                1: begin
                    if (ldok) nc = pv;
                    else if (ar) ns = 2;
                end
                2: begin
                    if (de) ns = 4;
                    else if (pa) ns = 3;
                    else if (se) begin
                        if (m_cnt == 1) begin nc = 0; ns = 5; end
                        else if (m_cnt > 0) nc = m_cnt - 1;
                    end
                end
                3: begin
                    if (de) ns = 4;
                    else if (ar) ns = 2;
                end
                default: ns = 0;
            endcase
            if (ns == 5) m_bl = 1'b1;
            else if (m_st == 2 && ns == 2 && m_cnt <= 10) m_bl = m_bl ^ hs;
            else m_bl = 1'b0;
            m_st  = ns;
            m_cnt = nc;
        end
    endtask

    initial begin
        int cyc;
        int tcnt;
        logic r_rstn, r_ld, r_ar, r_pa, r_de, r_se, r_hs;
        int r_pm, r_ps;

        drive(1'b0, 1'b0, 7'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        //             rstn ld  pm   ps  ar  pa  de  se  hs   st mi  sc  bl
        tbl.push_back(mk(0, 0,   0,  0,  0,  0,  0,  0,  0,   0, 0,  0,  0));
        tbl.push_back(mk(1, 1,   0,  3,  0,  0,  0,  0,  0,   1, 0,  3,  0));
        tbl.push_back(mk(1, 0,   0,  0,  1,  0,  0,  0,  0,   2, 0,  3,  0));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  0,  1,  1,   2, 0,  2,  1));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  0,  0,  1,   2, 0,  2,  0));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  0,  1,  1,   2, 0,  1,  1));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  0,  1,  1,   5, 0,  0,  1));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  0,  1,  1,   5, 0,  0,  1));
        tbl.push_back(mk(1, 1,   1,  0,  0,  0,  0,  0,  0,   1, 1,  0,  0));
        tbl.push_back(mk(1, 0,   0,  0,  1,  0,  0,  0,  0,   2, 1,  0,  0));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  0,  1,  0,   2, 0, 59,  0));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  0,  1,  0,   2, 0, 58,  0));
        tbl.push_back(mk(1, 1, 120, 63,  0,  0,  0,  0,  0,   2, 0, 58,  0));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  1,  0,  0,   4, 0, 58,  0));
        tbl.push_back(mk(1, 1, 120, 63,  0,  0,  0,  0,  0,   1, 99, 59, 0));
        tbl.push_back(mk(0, 0,   0,  0,  0,  0,  0,  0,  0,   0, 0,  0,  0));
        tbl.push_back(mk(1, 1,   0,  0,  0,  0,  0,  0,  0,   0, 0,  0,  0));
        tbl.push_back(mk(1, 1,   0,  5,  0,  0,  0,  0,  0,   1, 0,  5,  0));
        tbl.push_back(mk(1, 0,   0,  0,  1,  0,  0,  0,  0,   2, 0,  5,  0));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  1,  1,  1,   4, 0,  5,  0));
        tbl.push_back(mk(1, 1,   0, 20,  0,  0,  0,  0,  0,   1, 0, 20,  0));
        tbl.push_back(mk(1, 0,   0,  0,  1,  0,  0,  0,  0,   2, 0, 20,  0));
        tbl.push_back(mk(1, 0,   0,  0,  0,  1,  0,  1,  1,   3, 0, 20,  0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1,       3, 0, 20,  0));
        tbl.push_back(mk(1, 0,   0,  0,  1,  0,  0,  0,  0,   2, 0, 20,  0));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  0,  1,  0,   2, 0, 19,  0));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  1,  0,  0,   4, 0, 19,  0));
        tbl.push_back(mk(1, 1,   0, 10,  0,  0,  0,  0,  0,   1, 0, 10,  0));
        tbl.push_back(mk(1, 0,   0,  0,  1,  0,  0,  0,  0,   2, 0, 10,  0));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  0,  0,  1,   2, 0, 10,  1));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  0,  0,  1,   2, 0, 10,  0));
        tbl.push_back(mk(1, 0,   0,  0,  0,  1,  0,  0,  0,   3, 0, 10,  0));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  1,  0,  0,   4, 0, 10,  0));
        tbl.push_back(mk(1, 1,   0, 30,  0,  0,  0,  0,  0,   1, 0, 30,  0));
        tbl.push_back(mk(1, 0,   0,  0,  1,  0,  0,  0,  0,   2, 0, 30,  0));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  0,  0,  1,   2, 0, 30,  0));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  0,  0,  1,   2, 0, 30,  0));
        tbl.push_back(mk(1, 0,   0,  0,  0,  0,  1,  0,  0,   4, 0, 30,  0));
        tbl.push_back(mk(1, 1,   0,  7,  0,  0,  0,  0,  0,   1, 0,  7,  0));
        tbl.push_back(mk(1, 0,   0,  0,  1,  0,  0,  0,  0,   2, 0,  7,  0));
        tbl.push_back(mk(1, 0,   0,  0,  1,  0,  0,  0,  0,   2, 0,  7,  0));
        tbl.push_back(mk(0, 0,   0,  0,  1,  0,  0,  1,  1,   0, 0,  0,  0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rstn, tbl[i].ld, tbl[i].pm, tbl[i].ps, tbl[i].ar,
                  tbl[i].pa, tbl[i].de, tbl[i].se, tbl[i].hs);
            step();
            check($sformatf("table_%0d", i), tbl[i].st, tbl[i].mi, tbl[i].sc, tbl[i].bl);
        end

        // Worked example: 10-cycle timer, 00:03 preset explodes 30 cycles after arm.
        drive(1'b1, 1'b1, 7'd0, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("we_load", 1, 0, 3, 1'b0);
        drive(1'b1, 1'b0, 7'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("we_arm", 2, 0, 3, 1'b0);
        cyc  = 0;
        tcnt = 0;
        while ((state != 3'd5) && (cyc < 100)) begin
            if (timer_enable) tcnt++;
            drive(1'b1, 1'b0, 7'd0, 6'd0, 1'b1, 1'b0, 1'b0,
                  timer_enable && (tcnt % 10 == 0),
                  timer_enable && (tcnt % 5 == 0));
            step();
            cyc++;
        end
        n_vec++;
        if (cyc != 30) begin
            n_err++;
            $display("FAIL we_latency: exploded after %0d cycles, expected 30", cyc);
        end
        check("we_final", 5, 0, 0, 1'b1);

        // Random phase against the reference model, starting from reset.
        m_st = 0; m_cnt = 0; m_bl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r_rstn = (i == 0) ? 1'b0 : ($urandom_range(149, 0) != 0);
            r_ld   = ($urandom_range(11, 0) == 0);
            r_pm   = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(127, 0));
            r_ps   = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(63, 0));
            if ($urandom_range(3, 0) == 0) r_pm = 0;
            r_ar   = ($urandom_range(5, 0) == 0);
            r_pa   = ($urandom_range(15, 0) == 0);
            r_de   = ($urandom_range(59, 0) == 0);
            r_se   = ($urandom_range(2, 0) == 0);
            r_hs   = r_se || ($urandom_range(2, 0) == 0);
            drive(r_rstn, r_ld, r_pm[6:0], r_ps[5:0], r_ar, r_pa, r_de, r_se, r_hs);
            model_step(r_rstn, r_ld, r_pm, r_ps, r_ar, r_pa, r_de, r_se, r_hs);
            step();
            check($sformatf("rand_%0d", i), m_st, m_cnt / 60, m_cnt % 60, m_bl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
